// File: rtl/commit_trace_emitter_if.sv
// Valid/ready trace stream carrying one tagged 32-bit beat of a commit record.
// The emitter drives the master side; the capture sink owns ready.
interface commit_trace_emitter_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic [5:0]  tag;
    logic        last;

    modport master (output valid, output data, output tag, output last, input ready);
    modport slave  (input valid, input data, input tag, input last, output ready);
endinterface

// File: rtl/commit_trace_emitter.sv
// Commit trace emitter: on each retired instruction, holds the CPU and streams
// pc, instruction word and the first NUM_REGS GPRs as a tagged record.
module commit_trace_emitter #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   commit,
    input  logic [31:0]            commit_pc,
    input  logic [31:0]            commit_instr,
    output logic                   cpu_hold,
    output logic [4:0]             dbg_raddr,
    input  logic [31:0]            dbg_rdata,
    commit_trace_emitter_if.master trace,
    output logic [CNT_W-1:0]       commit_count,
    output logic                   overflow
);

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PC,
        S_INSTR,
        S_REG
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   pc_q;
    logic [DATA_W-1:0]   instr_q;
    logic                hold_q;
    logic                valid_q;
    logic [TAG_W-1:0]    tag_q;
    logic                last_q;
    logic [DATA_W-1:0]   data_c;
    logic                fire;

    assign fire = valid_q & trace.ready;

    // Record sequencer; hold and valid track "state != S_IDLE" as registered bits.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            pc_q         <= '0;
            instr_q      <= '0;
            hold_q       <= 1'b0;
            valid_q      <= 1'b0;
            tag_q        <= '0;
            last_q       <= 1'b0;
            commit_count <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (commit) begin
                        state        <= S_PC;
                        pc_q         <= commit_pc;
                        instr_q      <= commit_instr;
                        commit_count <= commit_count + CNT_W'(1);
                        hold_q       <= 1'b1;
                        valid_q      <= 1'b1;
                        tag_q        <= '0;
                        last_q       <= 1'b0;
                        idx          <= '0;
                    end
                end
                S_PC: begin
                    if (fire) begin
                        state <= S_INSTR;
                        tag_q <= TAG_W'(1);
                    end
                end
                S_INSTR: begin
                    if (fire) begin
                        state  <= S_REG;
                        idx    <= '0;
                        tag_q  <= TAG_W'(2);
                        last_q <= (LAST_IDX == '0);
                    end
                end
                S_REG: begin
                    if (fire) begin
                        if (idx == LAST_IDX) begin
                            state   <= S_IDLE;
                            idx     <= '0;
                            hold_q  <= 1'b0;
                            valid_q <= 1'b0;
                            tag_q   <= '0;
                            last_q  <= 1'b0;
                        end else begin
                            idx    <= idx + IDX_W'(1);
                            tag_q  <= tag_q + TAG_W'(1);
                            last_q <= ((idx + IDX_W'(1)) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // A commit seen while a record is in flight is dropped but remembered.
            if (commit && (state != S_IDLE)) begin
                overflow <= 1'b1;
            end
        end
    end

    // Register beats pass the debug port straight through; the CPU is frozen so it is stable.
    always_comb begin
        data_c = '0;
        case (state)
            S_PC:    data_c = pc_q;
            S_INSTR: data_c = instr_q;
            S_REG:   data_c = dbg_rdata;
            default: data_c = '0;
        endcase
    end

    assign cpu_hold    = hold_q;
    assign dbg_raddr   = idx;
    assign trace.valid = valid_q;
    assign trace.data  = data_c;
    assign trace.tag   = tag_q;
    assign trace.last  = last_q;

endmodule

// File: tb/tb_commit_trace_emitter.sv
// Bench for commit_trace_emitter: beat-queue reference model with per-cycle compare,
// directed records with literal expectations, a 4-register build, and random traffic.
module tb_commit_trace_emitter;

    localparam int unsigned NR = 32;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
        logic        last;
        logic        is_reg;
    } exp_t;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk_in  = 1'b0;
    logic        reset   = 1'b1;
    logic        commit  = 1'b0;
    logic        commit4 = 1'b0;
    logic [31:0] pc      = 32'h0;
    logic [31:0] instr   = 32'h0;
    logic        cpu_hold, hold4;
    logic [4:0]  raddr, raddr4;
    logic [31:0] rdata, rdata4;
    logic [31:0] count;
    logic [2:0]  count4;
    logic        ovf, ovf4;
    logic [31:0] regs [32];

    int n_checks = 0;
    int n_fail   = 0;
    int hold_cnt = 0;

    commit_trace_emitter_if tif();
    commit_trace_emitter_if tif4();

    assign rdata      = regs[raddr];
    assign rdata4     = regs[raddr4];
    assign tif4.ready = 1'b1;

    always #5 clk_in = ~clk_in;

    commit_trace_emitter #(.NUM_REGS(NR), .CNT_W(32)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .commit       (commit),
        .commit_pc    (pc),
        .commit_instr (instr),
        .cpu_hold     (cpu_hold),
        .dbg_raddr    (raddr),
        .dbg_rdata    (rdata),
        .trace        (tif),
        .commit_count (count),
        .overflow     (ovf)
    );

    commit_trace_emitter #(.NUM_REGS(4), .CNT_W(3)) dut4 (
        .clk_in       (clk_in),
        .reset        (reset),
        .commit       (commit4),
        .commit_pc    (pc),
        .commit_instr (instr),
        .cpu_hold     (hold4),
        .dbg_raddr    (raddr4),
        .dbg_rdata    (rdata4),
        .trace        (tif4),
        .commit_count (count4),
        .overflow     (ovf4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the record still owed to the sink, as a queue of beats.
    exp_t        exp_q[$];
    logic [31:0] m_count = 32'h0;
    logic        m_ovf   = 1'b0;

    function automatic exp_t mk(input int k, input logic [31:0] p, input logic [31:0] i);
        exp_t e;
        e.tag    = 6'(k);
        e.last   = (k == int'(NR) + 1);
        e.is_reg = (k >= 2);
        e.data   = (k == 0) ? p : ((k == 1) ? i : 32'h0);
        return e;
    endfunction

    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_count <= 32'h0;
            m_ovf   <= 1'b0;
        end else if (exp_q.size() == 0) begin
            if (commit) begin
                for (int k = 0; k < int'(NR) + 2; k++) exp_q.push_back(mk(k, pc, instr));
                m_count <= m_count + 32'd1;
            end
        end else begin
            if (commit) m_ovf <= 1'b1;
            if (tif.ready) void'(exp_q.pop_front());
        end
    end

    // Per-cycle compare against the model, plus a log of accepted beats.
    beat_t log_q[$];

    always @(negedge clk_in) begin
        chk("hold", 32'(cpu_hold), 32'(exp_q.size() != 0));
        chk("valid", 32'(tif.valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("tag", 32'(tif.tag), 32'(exp_q[0].tag));
            chk("data", tif.data,
                exp_q[0].is_reg ? regs[5'(exp_q[0].tag - 6'd2)] : exp_q[0].data);
            chk("last", 32'(tif.last), 32'(exp_q[0].last));
            if (exp_q[0].is_reg) chk("raddr", 32'(raddr), 32'(5'(exp_q[0].tag - 6'd2)));
            if (tif.valid && tif.ready) log_q.push_back('{tif.tag, tif.data, tif.last});
        end
        chk("count", count, m_count);
        chk("overflow", 32'(ovf), 32'(m_ovf));
        if (cpu_hold) hold_cnt++;
    end

    task automatic cycle();
        @(posedge clk_in);
        #2;
    endtask

    task automatic send(input logic [31:0] p, input logic [31:0] i);
        pc     = p;
        instr  = i;
        commit = 1'b1;
        cycle();
        commit = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input bit toggle);
        int n;
        n = 0;
        while (cpu_hold && n < bound) begin
            if (toggle) tif.ready = (n % 2 == 0);
            cycle();
            n++;
        end
        tif.ready = 1'b1;
        if (cpu_hold) chk("idle_timeout", 32'(cpu_hold), 32'h0);
    endtask

    // Literal record with regfile r1=1 and every other register 0.
    task automatic check_record(input string name, input logic [31:0] p, input logic [31:0] i);
        logic [31:0] d;
        chk({name, "_beats"}, 32'(log_q.size()), 32'(NR + 2));
        for (int k = 0; k < int'(NR) + 2 && k < log_q.size(); k++) begin
            d = (k == 0) ? p : ((k == 1) ? i : ((k == 3) ? 32'h1 : 32'h0));
            chk($sformatf("%s_tag%0d", name, k), 32'(log_q[k].tag), 32'(k));
            chk($sformatf("%s_data%0d", name, k), log_q[k].data, d);
            chk($sformatf("%s_last%0d", name, k), 32'(log_q[k].last), 32'(k == 33));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
        regs[1]   = 32'h1;
        tif.ready = 1'b1;
        repeat (3) @(posedge clk_in);
        #2 reset = 1'b0;
        chk("rst_count", count, 32'h0);
        chk("rst_hold", 32'(cpu_hold), 32'h0);
        chk("rst_valid", 32'(tif.valid), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        cycle();

        // Record 1: ready tied high
        log_q.delete();
        hold_cnt = 0;
        send(32'h00400000, 32'h24010001);
        wait_idle(200, 1'b0);
        check_record("rec1", 32'h00400000, 32'h24010001);
        chk("rec1_hold_cycles", 32'(hold_cnt), 32'd34);
        chk("rec1_count", count, 32'd1);

        // Record 2: commit in the first idle cycle, ready alternating
        log_q.delete();
        hold_cnt = 0;
        send(32'h00400004, 32'h24010001);
        wait_idle(300, 1'b1);
        check_record("rec2", 32'h00400004, 32'h24010001);
        chk("rec2_hold_cycles", 32'(hold_cnt), 32'd67);
        chk("rec2_count", count, 32'd2);
        chk("rec2_ovf", 32'(ovf), 32'h0);

        // Record 3: extra commit while beat 10 is on the bus
        cycle();
        cycle();
        log_q.delete();
        send(32'h00400008, 32'h24010001);
        repeat (10) cycle();
        chk("rec3_beat10", 32'(tif.tag), 32'd10);
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        wait_idle(200, 1'b0);
        check_record("rec3", 32'h00400008, 32'h24010001);
        chk("rec3_count", count, 32'd3);
        chk("rec3_ovf", 32'(ovf), 32'h1);
        repeat (5) cycle();
        chk("rec3_ovf_sticky", 32'(ovf), 32'h1);

        // Reset during beat 5
        send(32'h0040000c, 32'h24010001);
        repeat (5) cycle();
        chk("pre_rst_tag", 32'(tif.tag), 32'd5);
        reset = 1'b1;
        #1;
        chk("arst_hold", 32'(cpu_hold), 32'h0);
        chk("arst_valid", 32'(tif.valid), 32'h0);
        chk("arst_tag", 32'(tif.tag), 32'h0);
        chk("arst_data", tif.data, 32'h0);
        chk("arst_last", 32'(tif.last), 32'h0);
        chk("arst_raddr", 32'(raddr), 32'h0);
        chk("arst_count", count, 32'h0);
        chk("arst_ovf", 32'(ovf), 32'h0);
        cycle();
        reset = 1'b0;
        cycle();
        log_q.delete();
        send(32'h00400010, 32'h24010001);
        wait_idle(200, 1'b0);
        check_record("rec4", 32'h00400010, 32'h24010001);
        chk("rec4_count", count, 32'd1);

        // NUM_REGS=4 build: back-to-back records every 7 cycles, 3-bit count wraps
        for (int r = 0; r < 9; r++) begin
            pc      = 32'h00500000 + 32'(r * 4);
            instr   = 32'h20000000 + 32'(r);
            commit4 = 1'b1;
            cycle();
            commit4 = 1'b0;
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("n4_valid_r%0d_b%0d", r, i), 32'(tif4.valid), 32'h1);
                chk($sformatf("n4_tag_r%0d_b%0d", r, i), 32'(tif4.tag), 32'(i));
                chk($sformatf("n4_last_r%0d_b%0d", r, i), 32'(tif4.last), 32'(i == 5));
                chk($sformatf("n4_data_r%0d_b%0d", r, i), tif4.data,
                    (i == 0) ? 32'h00500000 + 32'(r * 4) :
                    (i == 1) ? 32'h20000000 + 32'(r) : ((i == 3) ? 32'h1 : 32'h0));
                cycle();
            end
            chk($sformatf("n4_idle_r%0d", r), 32'(hold4), 32'h0);
        end
        chk("n4_count_wrap", 32'(count4), 32'd1);
        chk("n4_ovf", 32'(ovf4), 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            commit    = ($urandom_range(0, 15) == 0);
            pc        = $urandom;
            instr     = $urandom;
            tif.ready = ($urandom_range(0, 3) != 0);
            if (exp_q.size() == 0) regs[$urandom_range(0, 31)] = $urandom;
            cycle();
        end
        commit    = 1'b0;
        tif.ready = 1'b1;
        wait_idle(200, 1'b0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_trace_emitter.md
Name: commit_trace_emitter

Overview:
- Hardware producer for the per-instruction commit trace of the multicycle CPU: pc, instruction word, then all 32 GPRs for each retired instruction.
- On each commit strobe it freezes the CPU with a hold signal, walks the register file through a debug read port, and streams a 34-beat record on a valid/ready interface.
- The record feeds a result-capture sink (sim bench or UART/FIFO logger) in place of hierarchical probing.
- Sits beside the CPU inside sccomp_dataflow.

Parameters:
NUM_REGS, 32, GPR words dumped per record (1..32); record length = NUM_REGS+2 beats.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk_in  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
commit  input  1  one-cycle strobe: an instruction retired this cycle (CPU's instr_change rising edge, synchronous).
commit_pc  input  32  pc of retired instruction, valid with commit.
commit_instr  input  32  ir contents of retired instruction, valid with commit.
cpu_hold  output  1  CPU must not advance or write the register file while high.
dbg_raddr  output  5  register file debug read address.
dbg_rdata  input  32  combinational read data for dbg_raddr.
trace_valid  output  1  beat valid.
trace_ready  input  1  sink accepts beat.
trace_data  output  32  beat payload.
trace_tag  output  6  0=pc, 1=instr, 2+k=reg k.
trace_last  output  1  final beat of record.
commit_count  output  CNT_W  records started since reset, wraps modulo 2^CNT_W.
overflow  output  1  sticky: a commit arrived while busy and was dropped.

Behaviour:
- Reset (async, immediate): state IDLE; trace_valid=0, trace_last=0, trace_tag=0, trace_data=0, cpu_hold=0, dbg_raddr=0, commit_count=0, overflow=0, latched pc/instr=0. Reset mid-record abandons the record; no partial beats after reset.
- States: IDLE, S_PC, S_INSTR, S_REG.
- IDLE: commit=1 at edge N latches commit_pc and commit_instr, increments commit_count, and moves to S_PC. From cycle N+1: cpu_hold=1 and trace_valid=1.
- cpu_hold = (state != IDLE); it is a decode of the state register, with no combinational path from commit.
- S_PC: data=latched pc, tag=0. On valid&ready go to S_INSTR.
- S_INSTR: data=latched instr, tag=1. On handshake go to S_REG with idx=0.
- S_REG: dbg_raddr=idx, data=dbg_rdata, tag=2+idx.
  - On handshake: idx++; if idx==NUM_REGS-1 go to IDLE.
  - trace_last=1 only when idx==NUM_REGS-1.
- Payload is stable while valid&!ready. The CPU is held, so dbg_rdata is stable.
- trace_valid never drops without a handshake.
- Latency with trace_ready tied 1: beats at cycles N+1..N+NUM_REGS+2; back in IDLE with hold=0 at cycle N+NUM_REGS+3. A new commit is accepted in that cycle.
- Backpressure: each ready=0 cycle extends the record and hold by one cycle. No beat is lost or duplicated.
- commit while state!=IDLE, including on the last-beat handshake cycle: dropped, overflow<=1 (sticky until reset), commit_count unchanged, current record unaffected.
- Register 0 is dumped as read; no forcing to zero here.
- commit_count wraps from all-ones to 0 silently.

Test Plan:
- Reset then one commit (pc=0x00400000, instr=0x24010001), ready=1, regfile r1=1, other regs 0 → 34 beats on consecutive cycles. Tags 0..33; data 0x00400000, 0x24010001, then 0, 1, 0×30. trace_last only on tag 33. cpu_hold high for exactly 34 cycles. commit_count=1.
- Same record with ready toggling 1,0,1,0… → 34 accepted beats with identical payload sequence; held beats stable; hold lasts 67 cycles.
- Commit in the first IDLE cycle after a record ends (pc=0x00400004) → accepted, second record starts next cycle, overflow=0, commit_count=2.
- Commit pulse during beat 10 of a record → record completes unchanged, overflow=1 and stays 1, commit_count not incremented.
- Assert reset during beat 5 with ready=1 → all outputs 0 immediately (before next clock edge). Next commit produces a full record starting at tag 0.
- NUM_REGS=4 build, back-to-back commits with ready=1 → 6-beat records, last on tag 5, 7-cycle commit spacing without overflow.
